// File: rtl/fm_pkg.sv
// Definitions shared by the FM step generator and its DDS neighbour: bus widths,
// the interpolator state type and the signed-to-unsigned clamp.
package fm_pkg;

  localparam int AUDIO_W = 16;
  localparam int STEP_W  = 10;

  typedef enum logic {
    IDLE,
    RAMP
  } interp_state_t;

  // Clamp a signed value into 0..max_val.
  function automatic int sat_clip(input int value, input int max_val);
    if (value < 0) return 0;
    if (value > max_val) return max_val;
    return value;
  endfunction

endpackage

// File: rtl/fm_interp.sv
// Linear interpolator: ramps from the current value to each new audio sample
// in exactly 2^INTERP_LOG2 equal steps, restarting if a sample arrives mid-ramp.
module fm_interp #(
  parameter int AUDIO_W     = fm_pkg::AUDIO_W,
  parameter int INTERP_LOG2 = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               audio_valid,
  output logic [AUDIO_W-1:0] interp,
  output logic               audio_ready,
  output logic               overrun
);
  import fm_pkg::*;

  localparam int ACC_W = AUDIO_W + INTERP_LOG2;
  localparam int DLT_W = AUDIO_W + 1;
  localparam logic [INTERP_LOG2-1:0] CNT_LAST = '1;

  interp_state_t           state, state_next;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [DLT_W-1:0] delta, delta_next;
  logic [INTERP_LOG2-1:0]  cnt, cnt_next;
  logic                    overrun_next;

  // The accumulator keeps INTERP_LOG2 fraction bits, so 2^INTERP_LOG2 adds of
  // delta land exactly on the target sample.
  assign interp      = acc[ACC_W-1:INTERP_LOG2];
  assign audio_ready = (state == IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch can be inferred.
    state_next   = state;
    acc_next     = acc;
    delta_next   = delta;
    cnt_next     = cnt;
    overrun_next = 1'b0;

    if (audio_valid) begin
      acc_next     = {interp, {INTERP_LOG2{1'b0}}};
      delta_next   = $signed({audio_in[AUDIO_W-1], audio_in})
                   - $signed({interp[AUDIO_W-1], interp});
      cnt_next     = '0;
      state_next   = RAMP;
      overrun_next = (state == RAMP);
    end else if (state == RAMP) begin
      acc_next = acc + ACC_W'(delta);
      cnt_next = cnt + INTERP_LOG2'(1);
      if (cnt == CNT_LAST) state_next = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      delta   <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      delta   <= delta_next;
      cnt     <= cnt_next;
      overrun <= overrun_next;
    end
  end

endmodule

// File: rtl/fm_step_gen.sv
// Converts the MPX audio stream into the DDS phase-increment word: interpolate,
// scale by the programmable deviation, add the carrier centre step, saturate.
module fm_step_gen #(
  parameter int AUDIO_W     = fm_pkg::AUDIO_W,
  parameter int STEP_W      = fm_pkg::STEP_W,
  parameter int INTERP_LOG2 = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               audio_valid,
  output logic               audio_ready,
  input  logic [STEP_W-1:0]  carrier_step,
  input  logic [2:0]         dev_shift,
  input  logic               enable,
  output logic [STEP_W-1:0]  step,
  output logic               sat,
  output logic               overrun
);
  import fm_pkg::*;

  localparam int SH_BASE  = AUDIO_W - STEP_W;
  localparam int STEP_MAX = (1 << STEP_W) - 1;

  logic [AUDIO_W-1:0] interp;
  int                 offset;
  int                 sum;
  int                 clip_val;
  logic               clipped;
  logic [STEP_W-1:0]  step_clip;

  fm_interp #(
    .AUDIO_W     (AUDIO_W),
    .INTERP_LOG2 (INTERP_LOG2)
  ) u_interp (
    .clock       (clock),
    .reset       (reset),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .interp      (interp),
    .audio_ready (audio_ready),
    .overrun     (overrun)
  );

  // The offset fits in STEP_W signed bits, so the carrier+offset sum never
  // leaves the STEP_W+2 signed range; 32-bit arithmetic gives the same result.
  always_comb begin
    offset    = int'($signed(interp)) >>> (SH_BASE + int'(dev_shift));
    sum       = int'(carrier_step) + offset;
    clip_val  = sat_clip(sum, STEP_MAX);
    clipped   = (clip_val != sum);
    step_clip = STEP_W'(clip_val);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step <= '0;
      sat  <= 1'b0;
    end else if (enable) begin
      step <= step_clip;
      sat  <= clipped;
    end else begin
      step <= carrier_step;
      sat  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_step_gen.sv
// Scoreboard bench for fm_step_gen: a closed-form ramp model predicts every
// registered output; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fm_step_gen;

  localparam int AUDIO_W     = 16;
  localparam int STEP_W      = 10;
  localparam int INTERP_LOG2 = 3;
  localparam int NSTEP       = 1 << INTERP_LOG2;
  localparam int STEP_MAX    = (1 << STEP_W) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [AUDIO_W-1:0] audio_in = '0;
  logic               audio_valid = 1'b0;
  logic               audio_ready;
  logic [STEP_W-1:0]  carrier_step = 10'd512;
  logic [2:0]         dev_shift = 3'd0;
  logic               enable = 1'b1;
  logic [STEP_W-1:0]  step;
  logic               sat;
  logic               overrun;

  fm_step_gen #(
    .AUDIO_W     (AUDIO_W),
    .STEP_W      (STEP_W),
    .INTERP_LOG2 (INTERP_LOG2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .audio_in     (audio_in),
    .audio_valid  (audio_valid),
    .audio_ready  (audio_ready),
    .carrier_step (carrier_step),
    .dev_shift    (dev_shift),
    .enable       (enable),
    .step         (step),
    .sat          (sat),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int step;
    int sat;
    int overrun;
    int ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Output register contents after an edge, from the pre-edge interpolated value.
  function automatic exp_t ref_out(input int interp, input int carrier, input int dev,
                                   input bit en, input bit ovr, input bit rdy);
    exp_t e;
    int   s;
    s         = carrier + (interp >>> (AUDIO_W - STEP_W + dev));
    e.overrun = int'(ovr);
    e.ready   = int'(rdy);
    e.sat     = 0;
    if (!en)               e.step = carrier;
    else if (s < 0)        begin e.step = 0;        e.sat = 1; end
    else if (s > STEP_MAX) begin e.step = STEP_MAX; e.sat = 1; end
    else                   e.step = s;
    return e;
  endfunction

  // Model: value k steps into a ramp is from + floor(k*(to-from)/NSTEP).
  int m_interp  = 0;
  int m_from    = 0;
  int m_to      = 0;
  int m_k       = 0;
  bit m_ramping = 1'b0;
  int m_pre;
  bit m_ovr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_interp  = 0;
      m_from    = 0;
      m_to      = 0;
      m_k       = 0;
      m_ramping = 1'b0;
      exp_q.delete();
    end else begin
      m_pre = m_interp;
      m_ovr = 1'b0;
      if (audio_valid) begin
        m_ovr     = m_ramping;
        m_from    = m_pre;
        m_to      = int'($signed(audio_in));
        m_k       = 0;
        m_ramping = 1'b1;
      end else if (m_ramping) begin
        m_k++;
        m_interp = m_from + ((m_k * (m_to - m_from)) >>> INTERP_LOG2);
        if (m_k == NSTEP) m_ramping = 1'b0;
      end
      exp_q.push_back(ref_out(m_pre, int'(carrier_step), int'(dev_shift), enable,
                              m_ovr, !m_ramping));
    end
  end

  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_step",    int'(step),        mon_e.step);
      check("sb_sat",     int'(sat),         mon_e.sat);
      check("sb_overrun", int'(overrun),     mon_e.overrun);
      check("sb_ready",   int'(audio_ready), mon_e.ready);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input int a);
    audio_in    = AUDIO_W'(a);
    audio_valid = 1'b1;
    tick(1);
    audio_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!audio_ready && n < budget) begin
      tick(1);
      n++;
    end
    check("ready_timeout", int'(audio_ready), 1);
  endtask

  task automatic settle(input int a, input string name, input int exp_step, input int exp_sat);
    send(a);
    wait_idle(4 * NSTEP);
    tick(2);
    check(name, int'(step), exp_step);
    check({name, "_sat"}, int'(sat), exp_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour.
    tick(2);
    check("rst_step",    int'(step),        0);
    check("rst_ready",   int'(audio_ready), 1);
    check("rst_sat",     int'(sat),         0);
    check("rst_overrun", int'(overrun),     0);
    reset = 1'b0;
    tick(1);
    check("post_rst_step", int'(step), 512);
    check("post_rst_sat",  int'(sat),  0);

    // Ramp 0 -> 16384: step climbs by 32 per cycle to 768.
    send(16384);
    tick(1);
    for (int k = 1; k <= NSTEP; k++) begin
      tick(1);
      check($sformatf("ramp_%0d", k), int'(step), 512 + 32 * k);
    end
    check("ramp_ready", int'(audio_ready), 1);
    tick(2);
    check("ramp_hold", int'(step), 768);

    // Full-scale swing with dev_shift=1.
    dev_shift = 3'd1;
    settle(-32768, "neg_full", 256, 0);
    settle(32767,  "pos_full", 767, 0);

    // Saturation at both rails.
    dev_shift    = 3'd0;
    carrier_step = 10'd1000;
    send(32767);
    tick(3);
    check("clip_hi",     int'(step), 1023);
    check("clip_hi_sat", int'(sat),  1);
    carrier_step = 10'd10;
    settle(-32768, "clip_lo", 0, 1);

    // Overrun three cycles into a ramp.
    carrier_step = 10'd512;
    settle(0, "zero", 512, 0);
    send(8000);
    tick(2);
    send(-8000);
    check("overrun_pulse", int'(overrun), 1);
    tick(1);
    check("overrun_clear", int'(overrun), 0);
    wait_idle(4 * NSTEP);
    tick(2);
    check("overrun_land", int'(step), 387);

    // Back-to-back valids.
    send(100);
    send(2000);
    check("b2b_overrun", int'(overrun), 1);
    send(-3000);
    check("b2b_overrun2", int'(overrun), 1);
    wait_idle(4 * NSTEP);
    tick(2);

    // Smallest deviation.
    dev_shift = 3'd7;
    settle(-32768, "dev7_lo", 508, 0);
    settle(32767,  "dev7_hi", 515, 0);

    // enable=0 mid-ramp, then async reset mid-ramp.
    dev_shift = 3'd0;
    send(-16384);
    tick(3);
    enable = 1'b0;
    tick(1);
    check("disable_step", int'(step), 512);
    carrier_step = 10'd700;
    tick(1);
    check("disable_carrier", int'(step), 700);
    enable       = 1'b1;
    carrier_step = 10'd512;
    send(16384);
    tick(2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_step",  int'(step),        0);
    check("async_rst_ready", int'(audio_ready), 1);
    check("async_rst_ovr",   int'(overrun),     0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      audio_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       audio_in = 16'h8000;
        1:       audio_in = 16'h7fff;
        default: audio_in = AUDIO_W'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) dev_shift    = 3'($urandom);
      if ($urandom_range(0, 49) == 0) carrier_step = STEP_W'($urandom);
      if ($urandom_range(0, 99) == 0) enable       = ~enable;
      tick(1);
    end
    audio_valid = 1'b0;
    wait_idle(4 * NSTEP);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
